// File: rtl/out_uart_tx_if.sv
// CPU-side output strobe/data and UART status signals for out_uart_tx.
// The CPU side takes the master modport and the transmitter takes the slave modport.
interface out_uart_tx_if #(
  parameter int DEPTH = 4
) ();
  logic                       doOut;
  logic [7:0]                 dbus;
  logic                       txd;
  logic                       busy;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       full;
  logic                       overflow;

  modport master (
    output doOut, dbus,
    input  txd, busy, count, full, overflow
  );

  modport slave (
    input  doOut, dbus,
    output txd, busy, count, full, overflow
  );
endinterface

// File: rtl/out_uart_tx.sv
// Serial output stage for the nic8 output register: captures bytes on doOut into a small FIFO
// and sends each one as an 8N1 UART frame on txd. Bytes that arrive while the FIFO is full are dropped.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (txd=0)
// DATA  | 8 data bits, LSB first
// STOP  | stop bit (txd=1); chains straight into START when more bytes are queued
module out_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DEPTH        = 4
) (
  input  logic         clk,
  input  logic         reset,
  out_uart_tx_if.slave bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int CCW = $clog2(CLKS_PER_BIT);
  localparam logic [CCW-1:0] CYC_LAST = CCW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state_q, state_d;
  logic [CCW-1:0] cyc_q, cyc_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           txd_q, txd_d;
  logic           busy_q, busy_d;

  logic [7:0]     mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           ovf_q, ovf_d;

  logic           full;
  logic           bit_end;
  logic           pop;
  logic           push_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign bit_end = (cyc_q == CYC_LAST);
  assign pop     = (count_q != '0) && ((state_q == IDLE) || ((state_q == STOP) && bit_end));
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign push_ok = bus.doOut && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (bus.doOut && !push_ok) ovf_d = 1'b1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = bit_end ? '0 : cyc_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        cyc_d = '0;
        if (pop) begin
          state_d = START;
          shift_d = mem_q[rd_ptr_q];
          txd_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
          txd_d   = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (pop) begin
            state_d = START;
            shift_d = mem_q[rd_ptr_q];
            txd_d   = 1'b0;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cyc_q    <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: only slots behind valid pointers are ever read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= bus.dbus;
  end

  assign bus.txd      = txd_q;
  assign bus.busy     = busy_q;
  assign bus.count    = count_q;
  assign bus.full     = full;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_out_uart_tx.sv
// Bench for out_uart_tx: a queue of expected bytes is filled as bytes are pushed,
// and a serial receiver on txd pops and compares each decoded frame.
module tb_out_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   frames   = 0;
  logic [7:0] exp_q [$];

  out_uart_tx_if #(.DEPTH(DEPTH)) bus ();

  out_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Receiver: detect the falling start edge, then sample each bit near its middle.
  bit         mon_on  = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte;
  always @(negedge clk) begin
    if (reset) begin
      mon_on = 1'b0;
    end else if (!mon_on) begin
      if (bus.txd == 1'b0) begin
        mon_on  = 1'b1;
        mon_cnt = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == 2) begin
        chk("start_bit", bus.txd, 0);
      end else if (mon_cnt >= 6 && mon_cnt <= 34 && (mon_cnt % 4) == 2) begin
        mon_byte[(mon_cnt - 6) / 4] = bus.txd;
      end else if (mon_cnt == 38) begin
        chk("stop_bit", bus.txd, 1);
        frames++;
        if (exp_q.size() == 0) chk("unexpected_frame", exp_q.size(), 1);
        else                   chk("frame_data", mon_byte, exp_q.pop_front());
        mon_on = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [7:0] b, input bit accept);
    bus.doOut = 1'b1;
    bus.dbus  = b;
    if (accept) exp_q.push_back(b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int w = 0;
    while ((bus.busy || bus.count != 0) && w < bound) begin
      @(negedge clk);
      w++;
    end
    chk(tag, (bus.busy || bus.count != 0), 0);
  endtask

  task automatic measure_busy(input string tag, input int exp_n);
    int n = 0;
    int w = 0;
    while (!bus.busy && w < 20) begin
      @(negedge clk);
      w++;
    end
    while (bus.busy && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk(tag, n, exp_n);
  endtask

  initial begin
    reset     = 1'b1;
    bus.doOut = 1'b0;
    bus.dbus  = 8'h00;
    #1;
    chk("rst_txd", bus.txd, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_ovf", bus.overflow, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 1: single byte, latency and frame length
    @(negedge clk);
    drive(8'h41, 1);
    @(negedge clk);
    bus.doOut = 1'b0;
    chk("t1_cnt_after_push", bus.count, 1);
    chk("t1_busy_after_push", bus.busy, 0);
    chk("t1_txd_after_push", bus.txd, 1);
    @(negedge clk);
    chk("t1_busy_after_pop", bus.busy, 1);
    chk("t1_txd_after_pop", bus.txd, 0);
    chk("t1_cnt_after_pop", bus.count, 0);
    measure_busy("t1_busy_len", 10 * CPB);
    chk("t1_cnt_end", bus.count, 0);
    chk("t1_txd_end", bus.txd, 1);

    // 2: back-to-back frames with no idle gap
    @(negedge clk);
    drive(8'h55, 1);
    @(negedge clk);
    drive(8'hAA, 1);
    @(negedge clk);
    bus.doOut = 1'b0;
    measure_busy("t2_busy_len", 20 * CPB);

    // 3: overflow
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 6) begin
        chk("t3_full", bus.full, 1);
        chk("t3_cnt_full", bus.count, DEPTH);
        chk("t3_ovf_before", bus.overflow, 0);
      end
      drive(8'(i), i <= 5);
    end
    @(negedge clk);
    bus.doOut = 1'b0;
    chk("t3_ovf_after", bus.overflow, 1);
    chk("t3_cnt_after", bus.count, DEPTH);
    wait_idle("t3_drain", 400);
    chk("t3_ovf_sticky", bus.overflow, 1);
    do_reset();
    chk("t3_ovf_cleared", bus.overflow, 0);

    // 4: push into a full FIFO on the STOP-end pop edge
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(8'h90 + 8'(i), 1);
    end
    @(negedge clk);
    bus.doOut = 1'b0;
    chk("t4_cnt_filled", bus.count, DEPTH);
    repeat (36) @(negedge clk);
    chk("t4_in_stop", bus.txd, 1);
    chk("t4_full_before", bus.full, 1);
    drive(8'hC4, 1);
    @(negedge clk);
    bus.doOut = 1'b0;
    chk("t4_cnt_after", bus.count, DEPTH);
    chk("t4_ovf_after", bus.overflow, 0);
    chk("t4_next_start", bus.txd, 0);
    wait_idle("t4_drain", 400);
    chk("t4_ovf_end", bus.overflow, 0);

    // 5: reset in the middle of data bit 3 of 8'hF0
    do_reset();
    @(negedge clk);
    drive(8'hF0, 1);
    @(negedge clk);
    drive(8'h11, 1);
    @(negedge clk);
    drive(8'h22, 1);
    @(negedge clk);
    bus.doOut = 1'b0;
    repeat (16) @(negedge clk);
    chk("t5_bit3", bus.txd, 0);
    chk("t5_busy_pre", bus.busy, 1);
    chk("t5_cnt_pre", bus.count, 2);
    reset = 1'b1;
    #1;
    chk("t5_txd_rst", bus.txd, 1);
    chk("t5_busy_rst", bus.busy, 0);
    chk("t5_cnt_rst", bus.count, 0);
    chk("t5_ovf_rst", bus.overflow, 0);
    chk("t5_full_rst", bus.full, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 6: idle hold after reset
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("t6_txd", bus.txd, 1);
      chk("t6_busy", bus.busy, 0);
      chk("t6_cnt", bus.count, 0);
    end

    chk("sb_empty", exp_q.size(), 0);
    chk("frames_total", frames, 1 + 2 + 5 + 6);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
